trame_tx_serializer: RTL and testbench

Frame serializer sitting directly downstream of the my_trame AXI4-Lite register file. It consumes the software-written control and payload registers, builds a byte-oriented frame (sync, length, payload, checksum) and streams it out on an AXI4-Stream-style byte interface toward the physical transmitter. One frame is in flight at a time; the register file keeps accepting writes while the frame drains.

---
 rtl/trame_pkg.sv | 36 +++
 rtl/trame_chk.sv | 49 ++++
 rtl/trame_tx_serializer.sv | 143 ++++++++++++++
 tb/tb_trame_tx_serializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/trame_pkg.sv
// +------------------------------------------------------------------+
// | trame_pkg: shared types, constants and checksum update functions   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package trame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CRC8_POLY         = 8'h07;

  // Byte-at-a-time CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] xor_update(input logic [7:0] crc, input logic [7:0] data);
    return crc ^ data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trame_chk.sv
// +------------------------------------------------------------------+
// | trame_chk: frame checksum accumulator (XOR, or CRC-8 when          |
// | TRAME_CRC8_EN is defined). Rev 1.0                                |
// +------------------------------------------------------------------+
`default_nettype none

module trame_chk
  import trame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] w_upd;

`ifdef TRAME_CRC8_EN
  assign w_upd = crc8_update(crc_q, din);
`else
  assign w_upd = xor_update(crc_q, din);
`endif

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = w_upd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/trame_tx_serializer.sv
// +------------------------------------------------------------------+
// | trame_tx_serializer: builds SYNC/LEN/payload/checksum byte frames  |
// | on a ready/valid byte stream. Option: TRAME_CRC8_EN. Rev 1.0      |
// +------------------------------------------------------------------+
`default_nettype none

module trame_tx_serializer
  import trame_pkg::*;
#(
  parameter int         NUM_WORDS = 3,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start,
  input  logic [1:0]                word_count,
  input  logic [32*NUM_WORDS-1:0]   payload,
  output logic [7:0]                m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      busy,
  output logic                      done,
  output logic                      start_drop
);

  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(4 * NUM_WORDS) : 2;

  state_t                    state_q, state_d;
  logic [1:0]                wc_q, wc_d;
  logic [32*NUM_WORDS-1:0]   payload_q, payload_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      drop_q, drop_d;

  logic                      w_hs;
  logic                      w_chk_clr;
  logic                      w_chk_en;
  logic [7:0]                w_chk;
  logic [7:0]                w_len_byte;
  logic [7:0]                w_data_byte;
  logic                      w_last_data;
  logic [1:0]                w_wc_clamped;

  assign w_wc_clamped = (int'(word_count) > NUM_WORDS) ? 2'(NUM_WORDS) : word_count;
  assign w_len_byte   = {4'b0000, wc_q, 2'b00};
  assign w_data_byte  = payload_q[{cnt_q, 3'b000} +: 8];
  assign w_last_data  = ({{(8-CNT_W){1'b0}}, cnt_q} == (w_len_byte - 8'd1));
  // Handshake derived from state rather than m_tvalid to keep the comb path flat.
  assign w_hs         = (state_q != ST_IDLE) && m_tready;

  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    payload_d = payload_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    drop_d    = start && (state_q != ST_IDLE);
    w_chk_clr = 1'b0;
    w_chk_en  = 1'b0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tdata   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wc_d      = w_wc_clamped;
          payload_d = payload;
          cnt_d     = '0;
          w_chk_clr = 1'b1;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        m_tvalid = 1'b1;
        m_tdata  = SYNC_BYTE;
        if (w_hs) state_d = ST_LEN;
      end
      ST_LEN: begin
        m_tvalid = 1'b1;
        m_tdata  = w_len_byte;
        if (w_hs) begin
          w_chk_en = 1'b1;
          cnt_d    = '0;
          state_d  = (wc_q == 2'd0) ? ST_CHK : ST_DATA;
        end
      end
      ST_DATA: begin
        m_tvalid = 1'b1;
        m_tdata  = w_data_byte;
        if (w_hs) begin
          w_chk_en = 1'b1;
          if (w_last_data) state_d = ST_CHK;
          else             cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_CHK: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tdata  = w_chk;
        if (w_hs) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      wc_q      <= 2'd0;
      payload_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wc_q      <= wc_d;
      payload_q <= payload_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  trame_chk u_chk (
    .clk (ACLK),
    .rst (ARESET),
    .clr (w_chk_clr),
    .en  (w_chk_en),
    .din (m_tdata),
    .crc (w_chk)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign start_drop = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_trame_tx_serializer.sv
// +------------------------------------------------------------------+
// | tb_trame_tx_serializer: self-checking bench for the frame          |
// | serializer (vector table + randomized frames). Rev 1.0            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_trame_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  word_count = 2'd0;
  logic [95:0] payload = '0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        busy;
  logic        done;
  logic        start_drop;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trame_tx_serializer #(
    .NUM_WORDS (3),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .ACLK       (clk),
    .ARESET     (rst),
    .start      (start),
    .word_count (word_count),
    .payload    (payload),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .busy       (busy),
    .done       (done),
    .start_drop (start_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference checksum: bit-serial LFSR over the message, or plain XOR.
  function automatic logic [7:0] ref_chk(input logic [7:0] msg[$]);
    logic [7:0] c = 8'h00;
    foreach (msg[i]) begin
`ifdef TRAME_CRC8_EN
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb = c[7] ^ msg[i][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
`else
      c = c ^ msg[i];
`endif
    end
    return c;
  endfunction

  // Expected frame as a byte list, straight from the frame format rules.
  function automatic void ref_frame(input logic [1:0] wc, input logic [95:0] pl, output logic [7:0] fr[$]);
    logic [7:0] cov[$];
    int n;
    n = 4 * int'(wc);
    fr.delete();
    cov.delete();
    cov.push_back(8'(n));
    for (int k = 0; k < n; k++) cov.push_back(8'((pl >> (8 * k)) & 96'hFF));
    fr.push_back(8'hA5);
    foreach (cov[i]) fr.push_back(cov[i]);
    fr.push_back(ref_chk(cov));
  endfunction

  // Runs one frame from the IDLE state. inject >= 0 pulses start (and rewrites
  // payload) right after the byte with that index is accepted.
  task automatic run_frame(input logic [1:0] wc, input logic [95:0] pl, input bit stall,
                           input int inject, output logic [7:0] chk_out, output int cycles);
    logic [7:0] exp[$];
    int n, idx, drop_state;
    bit prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    ref_frame(wc, pl, exp);
    n = exp.size();
    chk_out = 8'h00;
    @(negedge clk);
    word_count = wc;
    payload    = pl;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    word_count = 2'($urandom);
    payload    = {$urandom, $urandom, $urandom};
    cycles = 0; idx = 0; drop_state = 0;
    prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    while (idx < n && cycles < 400) begin
      if (drop_state == 2) begin
        check("start_drop_pulse", {31'b0, start_drop}, 32'd1);
        drop_state = 1;
      end else if (drop_state == 1) begin
        check("start_drop_single", {31'b0, start_drop}, 32'd0);
        drop_state = 0;
      end
      start    = 1'b0;
      m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("tvalid_in_frame", {31'b0, m_tvalid}, 32'd1);
      if (prev_stall) begin
        check("stall_data_stable", {24'b0, m_tdata}, {24'b0, prev_data});
        check("stall_last_stable", {31'b0, m_tlast}, {31'b0, prev_last});
      end
      if (m_tready) begin
        check($sformatf("byte%0d", idx), {24'b0, m_tdata}, {24'b0, exp[idx]});
        check($sformatf("tlast%0d", idx), {31'b0, m_tlast}, {31'b0, (idx == n - 1)});
        if (idx == n - 1) chk_out = m_tdata;
        if (idx == inject) begin
          start   = 1'b1;
          payload = ~pl;
          drop_state = 2;
        end
        idx++;
      end
      prev_stall = !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    if (idx < n) check("frame_timeout", 32'(idx), 32'(n));
    #1;
    check("done_after_chk", {31'b0, done}, 32'd1);
    check("busy_fall", {31'b0, busy}, 32'd0);
    check("idle_tvalid", {31'b0, m_tvalid}, 32'd0);
    @(negedge clk);
    #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("no_second_frame", {31'b0, m_tvalid}, 32'd0);
    m_tready = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  wc;
    logic [95:0] pl;
    bit          stall;
    int          inject;
    bit          has_chk;
    logic [7:0]  chk;
  } vec_t;

  initial begin
    vec_t vecs[5];
    logic [7:0] chk;
    int cyc;
    logic [7:0] spec_chk;
`ifdef TRAME_CRC8_EN
    spec_chk = 8'h99;
`else
    spec_chk = 8'h05;
`endif
    vecs[0] = '{2'd1, 96'h00000001, 1'b0, -1, 1'b1, spec_chk};
    vecs[1] = '{2'd0, 96'h12345678, 1'b0, -1, 1'b1, 8'h00};
    vecs[2] = '{2'd3, 96'h99AABBCC_55667788_11223344, 1'b1, -1, 1'b0, 8'h00};
    vecs[3] = '{2'd3, 96'hDEADBEEF_CAFEF00D_01020304, 1'b0, 5, 1'b0, 8'h00};
    vecs[4] = '{2'd2, 96'h0BADF00D_A5A5A5A5_FFFFFFFF, 1'b1, 3, 1'b0, 8'h00};

    #2;
    check("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    check("rst_tlast", {31'b0, m_tlast}, 32'd0);
    check("rst_tdata", {24'b0, m_tdata}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_drop", {31'b0, start_drop}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_frame(vecs[i].wc, vecs[i].pl, vecs[i].stall, vecs[i].inject, chk, cyc);
      if (vecs[i].has_chk) check($sformatf("vec%0d_chk", i), {24'b0, chk}, {24'b0, vecs[i].chk});
      if (!vecs[i].stall) check($sformatf("vec%0d_len", i), 32'(cyc), 32'(3 + 4 * int'(vecs[i].wc)));
    end

    // Reset in the middle of DATA.
    @(negedge clk);
    word_count = 2'd3;
    payload    = {$urandom, $urandom, $urandom};
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_tvalid", {31'b0, m_tvalid}, 32'd0);
    check("arst_tlast", {31'b0, m_tlast}, 32'd0);
    check("arst_tdata", {24'b0, m_tdata}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_rst_done", {31'b0, done}, 32'd0);
      check("post_rst_idle", {31'b0, m_tvalid}, 32'd0);
    end
    run_frame(2'd1, 96'h00000001, 1'b0, -1, chk, cyc);
    check("post_rst_chk", {24'b0, chk}, {24'b0, spec_chk});

    for (int r = 0; r < 25; r++) begin
      logic [1:0]  wc;
      logic [95:0] pl;
      wc = 2'($urandom_range(0, 3));
      pl = {$urandom, $urandom, $urandom};
      run_frame(wc, pl, 1'($urandom_range(0, 1)), -1, chk, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
